dm_run_seq: RTL
===============

Name: dm_run_seq

Overview:
Program-run sequencer that sits directly upstream of the core (top) and its data memory.
- Holds the core in reset.
- Streams operand bytes into data memory.
- Releases the core and waits for done.
- Streams a configured result window back out.
It is the hardware equivalent of the bench's load, reset-pulse, wait(done), readback sequence, so all three programs can run without testbench backdoor pokes.

Parameters:
AW, 8, data-memory address width (256 entries)
DW, 8, data-memory word width
TW, 16, timeout counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  run request valid
cfg_ready  out  1  high only in IDLE
cfg_ld_base  in  AW  first load address
cfg_ld_len  in  AW  number of bytes to load (0 = none)
cfg_rd_base  in  AW  first result address
cfg_rd_len  in  AW  number of result bytes (0 = none)
cfg_timeout  in  TW  max RUN cycles (0 = disabled)
in_valid  in  1  operand byte valid
in_ready  out  1  operand byte accepted
in_data  in  DW  operand byte
dm_sel  out  1  block owns the data-memory port
dm_addr  out  AW  data-memory address
dm_we  out  1  data-memory write enable
dm_wdata  out  DW  data-memory write data
dm_rdata  in  DW  data-memory read data, 1-cycle latency
core_reset  out  1  active-high reset to core
core_done  in  1  core done flag
out_valid  out  1  result byte valid
out_ready  in  1  result byte accepted
out_data  out  DW  result byte
out_last  out  1  final result byte of the run
busy  out  1  state is not IDLE
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values (asynchronous assert, synchronous-release domain): state=IDLE, core_reset=1, all other outputs 0, counters 0.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid, latch all cfg_* fields and clear err_timeout.
  - Next state is LOAD if ld_len!=0, else START.
- LOAD:
  - dm_sel=1, in_ready=1.
  - Each cycle with in_valid: dm_we=1, dm_addr=ld_ptr, dm_wdata=in_data, ld_ptr++, count++.
  - When count==ld_len, go to START.
  - ld_ptr wraps modulo 2^AW.
- START:
  - core_reset=1 for exactly 2 cycles, dm_sel=0.
  - Then go to RUN.
- RUN:
  - core_reset=0, dm_sel=0.
  - The timer counts RUN cycles starting at 1.
  - core_done=1 sampled: go to DRAIN (a 1-cycle settle state, core_reset=1). Then go to RD if rd_len!=0, else IDLE.
  - If cfg_timeout!=0 and the timer reaches cfg_timeout without done: go to IDLE, set err_timeout=1, core_reset=1.
  - If done and the timeout coincide in the same cycle, done wins.
- RD:
  - dm_sel=1, dm_addr=rd_ptr; core_reset stays 1.
  - Next cycle, capture dm_rdata into the out register, set out_valid=1, and go to OUT.
- OUT:
  - Hold out_valid, out_data and out_last stable until out_ready.
  - On handshake: rd_ptr++ (wraps), count++.
  - If count==rd_len, go to IDLE; otherwise go to RD.
  - Minimum throughput is 1 byte per 2 cycles.
- out_last=1 only on the byte whose index is rd_len-1.
- core_reset=1 in every state except RUN.
- dm_we=1 only in LOAD.
- cfg_valid outside IDLE is ignored; cfg_ready=0 there.
- in_valid outside LOAD is ignored; in_ready=0 there.
- reset low mid-run: immediate return to IDLE, core_reset=1, out_valid=0. The partial load is not undone.

Decomposition:
- Shared package run_seq_pkg:
  - state enum {IDLE, LOAD, START, RUN, DRAIN, RD, OUT}
  - AW/DW/TW defaults
  - START_CYCLES=2
- One sub-module, run_timer: clear, enable and compare against the limit, producing `expired`. It is reusable for other watchdogs.

Test Plan:
- Multiply case:
  - Stimulus: ld_base=1, ld_len=3, bytes 10,36,3. A core model writes 0x04 to address 4 and 0x38 to address 5, then raises done. rd_base=4, rd_len=2.
  - Required response: out 0x04, then 0x38 with out_last; 1080=0x0438.
- Backpressure:
  - Stimulus: same run, out_ready low for 5 cycles on the first byte.
  - Required response: out_data holds 0x04 stable; no byte is lost or duplicated.
- Timeout:
  - Stimulus: cfg_timeout=20, core never asserts done.
  - Required response: err_timeout=1 after 20 RUN cycles, state IDLE, core_reset=1, no out_valid.
- Wrap and zero length:
  - Stimulus: ld_base=254, ld_len=4.
  - Required response: writes to 254,255,0,1.
  - Stimulus: ld_len=0, rd_len=0.
  - Required response: goes straight to START then RUN, and returns to IDLE after done with no out_valid.
- Reset mid-LOAD:
  - Stimulus: reset low after 2 of 3 bytes.
  - Required response: immediate IDLE, core_reset=1, busy=0. A new cfg is accepted next cycle after release.
- Done and timeout coincident:
  - Stimulus: done asserted on timer cycle 20 with cfg_timeout=20.
  - Required response: err_timeout stays 0 and unload proceeds.

Source files
------------

// File: rtl/run_seq_pkg.sv
// ============================================================================
// run_seq_pkg : shared types and defaults for the program-run sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_seq_pkg;

    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 8;
    localparam int TW_DEF       = 16;
    localparam int START_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_RD    = 3'd5,
        S_OUT   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dm_run_seq_timer.sv
// ============================================================================
// run_timer : cycle counter with clear/enable that flags when the next counted
//             cycle reaches a non-zero limit (limit 0 disables the watchdog)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [TW-1:0] limit_i,
    output logic          expired_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // count_d is the 1-based index of the cycle currently being counted
    assign count_d   = count_q + TW'(1);
    assign expired_o = en_i && (limit_i != '0) && (count_d == limit_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_run_seq.sv
// ============================================================================
// dm_run_seq : loads operands into data memory, runs the core until done or
//              timeout, then streams a result window out
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_run_seq
    import run_seq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [AW-1:0] cfg_ld_base_i,
    input  logic [AW-1:0] cfg_ld_len_i,
    input  logic [AW-1:0] cfg_rd_base_i,
    input  logic [AW-1:0] cfg_rd_len_i,
    input  logic [TW-1:0] cfg_timeout_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          dm_sel_o,
    output logic [AW-1:0] dm_addr_o,
    output logic          dm_we_o,
    output logic [DW-1:0] dm_wdata_o,
    input  logic [DW-1:0] dm_rdata_i,
    output logic          core_reset_o,
    input  logic          core_done_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          err_timeout_o
);

    localparam logic [AW-1:0] ONE        = AW'(1);
    localparam logic [AW-1:0] START_LAST = AW'(START_CYCLES - 1);

    state_e        state_q;
    logic [AW-1:0] ld_len_q;
    logic [AW-1:0] rd_len_q;
    logic [AW-1:0] ld_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] count_q;
    logic [TW-1:0] timeout_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [DW-1:0] out_data_q;
    logic          err_q;

    logic [AW-1:0] ld_ptr_d;
    logic [AW-1:0] rd_ptr_d;
    logic [AW-1:0] count_d;
    logic          expired;

    assign ld_ptr_d = ld_ptr_q + ONE;
    assign rd_ptr_d = rd_ptr_q + ONE;
    assign count_d  = count_q + ONE;

    run_timer #(
        .TW (TW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q != S_RUN),
        .en_i      (state_q == S_RUN),
        .limit_i   (timeout_q),
        .expired_o (expired)
    );

    assign cfg_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign in_ready_o    = (state_q == S_LOAD);
    assign dm_we_o       = (state_q == S_LOAD) && in_valid_i;
    assign dm_wdata_o    = (state_q == S_LOAD) ? in_data_i : '0;
    assign core_reset_o  = (state_q != S_RUN);
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign err_timeout_o = err_q;

    // The memory has one cycle of read latency, so each read address is put
    // on the bus one cycle ahead (DRAIN for the first byte, OUT for the rest)
    // and the returned word is valid throughout RD.
    assign dm_sel_o = (state_q == S_LOAD) || (state_q == S_RD) || (state_q == S_OUT) ||
                      ((state_q == S_DRAIN) && (rd_len_q != '0));

    always_comb begin
        dm_addr_o = '0;
        case (state_q)
            S_LOAD:        dm_addr_o = ld_ptr_q;
            S_DRAIN, S_RD: dm_addr_o = rd_ptr_q;
            S_OUT:         dm_addr_o = rd_ptr_d;
            default:       dm_addr_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_len_q    <= '0;
            rd_len_q    <= '0;
            ld_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timeout_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        ld_len_q  <= cfg_ld_len_i;
                        rd_len_q  <= cfg_rd_len_i;
                        ld_ptr_q  <= cfg_ld_base_i;
                        rd_ptr_q  <= cfg_rd_base_i;
                        timeout_q <= cfg_timeout_i;
                        count_q   <= '0;
                        err_q     <= 1'b0;
                        state_q   <= (cfg_ld_len_i != '0) ? S_LOAD : S_START;
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        ld_ptr_q <= ld_ptr_d;
                        if (count_d == ld_len_q) begin
                            count_q <= '0;
                            state_q <= S_START;
                        end else begin
                            count_q <= count_d;
                        end
                    end
                end
                S_START: begin
                    if (count_q == START_LAST) begin
                        count_q <= '0;
                        state_q <= S_RUN;
                    end else begin
                        count_q <= count_d;
                    end
                end
                S_RUN: begin
                    if (core_done_i) begin
                        state_q <= S_DRAIN;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    count_q <= '0;
                    state_q <= (rd_len_q != '0) ? S_RD : S_IDLE;
                end
                S_RD: begin
                    out_data_q  <= dm_rdata_i;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (count_q == (rd_len_q - ONE));
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        rd_ptr_q    <= rd_ptr_d;
                        if (count_d == rd_len_q) begin
                            count_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            count_q <= count_d;
                            state_q <= S_RD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
